// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default parameters for the memory port arbiter
// Contents: state_t (IDLE/ISSUE/RESP), owner_t (OWN_IF/OWN_D), DEF_* parameter defaults.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_MAX_D_STREAK = 4;
   localparam int DEF_TIMEOUT      = 255;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory handshake bundle
// Fetch side:  if_req, if_addr -> if_done, if_err, if_rdata
// Data side:   d_req, d_we, d_addr, d_wdata, d_be -> d_done, d_err, d_rdata
// Memory side: mem_req, mem_we, mem_addr, mem_wdata, mem_be -> mem_ack, mem_rdata
// slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_done;
   logic                  if_err;
   logic [DATA_W-1:0]     if_rdata;
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_be;
   logic                  d_done;
   logic                  d_err;
   logic [DATA_W-1:0]     d_rdata;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
      output if_done, if_err, if_rdata, d_done, d_err, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
      input  if_done, if_err, if_rdata, d_done, d_err, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational grant decision between fetch and data requesters
// Inputs:  i_if_req, i_d_req, i_streak_full
// Outputs: o_grant_valid (any request), o_owner (data wins unless its streak is used up)
module arb_pick import mem_arb_pkg::*; (
   input  logic   i_if_req,
   input  logic   i_d_req,
   input  logic   i_streak_full,
   output logic   o_grant_valid,
   output owner_t o_owner
);
   always_comb begin
      o_grant_valid = i_if_req || i_d_req;
      o_owner       = (i_d_req && !(i_if_req && i_streak_full)) ? OWN_D : OWN_IF;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
// Ports: clk, rst (async, active high), io_bus (mem_port_arbiter_if.slave).
// Each access runs IDLE (grant + latch) -> ISSUE (mem_req until ack/timeout) -> RESP (done pulse).
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave io_bus
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = DATA_W / 8;
   state_t            r_state;
   owner_t            r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BW-1:0]     r_be;
   logic              r_mem_req;
   logic [SW-1:0]     r_streak;
   logic [TW-1:0]     r_tcnt;
   logic              r_if_done;
   logic              r_if_err;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_d_done;
   logic              r_d_err;
   logic [DATA_W-1:0] r_d_rdata;
   logic              w_grant;
   owner_t            w_owner;
   logic              w_full;
   logic              w_tlast;
   logic              w_fin;
   logic [DATA_W-1:0] w_rdata;
   assign w_full  = r_streak == SW'(MAX_D_STREAK);
   // Last permitted ISSUE cycle; an ack in this same cycle still counts as success.
   assign w_tlast = r_tcnt == TW'(TIMEOUT - 1);
   assign w_fin   = io_bus.mem_ack || w_tlast;
   // Stores and timeouts return zero data.
   assign w_rdata = (io_bus.mem_ack && !r_we) ? io_bus.mem_rdata : '0;
   arb_pick u_pick (
      .i_if_req      (io_bus.if_req),
      .i_d_req       (io_bus.d_req),
      .i_streak_full (w_full),
      .o_grant_valid (w_grant),
      .o_owner       (w_owner)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_owner    <= OWN_IF;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_mem_req  <= 1'b0;
         r_streak   <= '0;
         r_tcnt     <= '0;
         r_if_done  <= 1'b0;
         r_if_err   <= 1'b0;
         r_if_rdata <= '0;
         r_d_done   <= 1'b0;
         r_d_err    <= 1'b0;
         r_d_rdata  <= '0;
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;
         case (r_state)
            IDLE: if (w_grant) begin
               r_owner   <= w_owner;
               r_we      <= w_owner == OWN_D && io_bus.d_we;
               r_addr    <= w_owner == OWN_D ? io_bus.d_addr : io_bus.if_addr;
               r_wdata   <= w_owner == OWN_D ? io_bus.d_wdata : '0;
               r_be      <= w_owner == OWN_D ? io_bus.d_be : '1;
               // Streak only grows while fetch is actually being held off.
               r_streak  <= (w_owner == OWN_D && io_bus.if_req) ? (w_full ? r_streak : r_streak + SW'(1)) : '0;
               r_tcnt    <= '0;
               r_mem_req <= 1'b1;
               r_state   <= ISSUE;
            end
            ISSUE: begin
               r_tcnt <= r_tcnt + TW'(1);
               if (w_fin) begin
                  r_mem_req <= 1'b0;
                  r_state   <= RESP;
                  if (r_owner == OWN_D) begin
                     r_d_done  <= 1'b1;
                     r_d_err   <= !io_bus.mem_ack;
                     r_d_rdata <= w_rdata;
                  end else begin
                     r_if_done  <= 1'b1;
                     r_if_err   <= !io_bus.mem_ack;
                     r_if_rdata <= w_rdata;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io_bus.mem_req   = r_mem_req;
   assign io_bus.mem_we    = r_we;
   assign io_bus.mem_addr  = r_addr;
   assign io_bus.mem_wdata = r_wdata;
   assign io_bus.mem_be    = r_be;
   assign io_bus.if_done   = r_if_done;
   assign io_bus.if_err    = r_if_err;
   assign io_bus.if_rdata  = r_if_rdata;
   assign io_bus.d_done    = r_d_done;
   assign io_bus.d_err     = r_d_err;
   assign io_bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench with a transaction-timing reference model
module tb_mem_port_arbiter;
   localparam int AW = 32, DW = 32, BW = 4, MAXS = 4, TO = 5;
   typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be;} dreq_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );
   int n_cmp = 0, n_bad = 0, cyc = 0, phase = 0;
   bit act = 1'b0, own_d = 1'b0, ack_ok = 1'b0;
   int e = 0, k = 0, nxt = 1, streak = 0;
   logic m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd, m_rd;
   logic [BW-1:0] m_be;
   int dly_q[$];
   logic [DW-1:0] rd_q[$];
   dreq_t d_script[$];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic dreq_t rnd_d();
      dreq_t r;
      r.we = 1'($urandom_range(1));
      r.addr = $urandom;
      r.wdata = $urandom;
      r.be = 4'($urandom);
      return r;
   endfunction
   function automatic bit roll();
      return phase == 1 || (phase == 2 && $urandom_range(1) == 1);
   endfunction
   task automatic new_if();
      bus.if_req = 1'b1;
      bus.if_addr = $urandom;
   endtask
   task automatic new_d(input dreq_t r);
      bus.d_req = 1'b1;
      bus.d_we = r.we;
      bus.d_addr = r.addr;
      bus.d_wdata = r.wdata;
      bus.d_be = r.be;
   endtask
   // Reference decision at an IDLE sampling edge: who wins, what gets latched, how long it lasts.
   task automatic decide(input int edge_n);
      int d;
      if (!bus.if_req && !bus.d_req) begin
         nxt = edge_n + 1;
         return;
      end
      own_d = bus.d_req && !(bus.if_req && streak >= MAXS);
      if (own_d && bus.if_req) streak = streak < MAXS ? streak + 1 : MAXS;
      else streak = 0;
      m_we = own_d ? bus.d_we : 1'b0;
      m_addr = own_d ? bus.d_addr : bus.if_addr;
      m_wd = bus.d_wdata;
      m_be = own_d ? bus.d_be : 4'hF;
      d = dly_q.size() > 0 ? dly_q.pop_front() : int'($urandom_range(1, TO + 2));
      ack_ok = d <= TO;
      k = ack_ok ? d : TO;
      m_rd = rd_q.size() > 0 ? rd_q.pop_front() : $urandom;
      e = edge_n;
      act = 1'b1;
      nxt = e + k + 2;
   endtask
   // Called at the falling edge of the cycle following rising edge number cyc.
   task automatic step();
      bit issue, done;
      logic [DW-1:0] xr;
      if (phase == 1 && cyc >= 200) phase = 2;
      if (phase == 2 && cyc >= 1500) phase = 3;
      issue = act && cyc >= e && cyc < e + k;
      done = act && cyc == e + k;
      chk("mem_req", bus.mem_req, issue);
      if (issue) begin
         chk("mem_addr", bus.mem_addr, m_addr);
         chk("mem_we", bus.mem_we, m_we);
         chk("mem_be", bus.mem_be, m_be);
         if (own_d) chk("mem_wdata", bus.mem_wdata, m_wd);
      end
      chk("if_done", bus.if_done, done && !own_d);
      chk("d_done", bus.d_done, done && own_d);
      if (done) begin
         xr = (ack_ok && !m_we) ? m_rd : '0;
         act = 1'b0;
         if (own_d) begin
            chk("d_rdata", bus.d_rdata, xr);
            chk("d_err", bus.d_err, !ack_ok);
            if (phase == 0) begin
               if (d_script.size() > 0) new_d(d_script.pop_front());
               else begin
                  bus.d_req = 1'b0;
                  phase = 1;
               end
            end else if (phase == 3 || !roll()) bus.d_req = 1'b0;
            else new_d(rnd_d());
         end else begin
            chk("if_rdata", bus.if_rdata, xr);
            chk("if_err", bus.if_err, !ack_ok);
            if (phase == 0 || phase == 3 || !roll()) bus.if_req = 1'b0;
            else new_if();
         end
      end
      if (!bus.if_req && (phase == 1 || phase == 2) && roll()) new_if();
      if (!bus.d_req) begin
         if (phase == 0 && cyc >= 4 && d_script.size() > 0) new_d(d_script.pop_front());
         else if ((phase == 1 || phase == 2) && roll()) new_d(rnd_d());
      end
      if (cyc + 1 == nxt) decide(cyc + 1);
      bus.mem_ack = issue ? (ack_ok && cyc == e + k - 1) : ($urandom_range(7) == 0);
      bus.mem_rdata = (issue && bus.mem_ack) ? m_rd : $urandom;
   endtask
   task automatic cycle();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      step();
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      int guard;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_done", bus.if_done, 0);
      chk("rst_d_done", bus.d_done, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      // Directed opening: fetch 0x10 acked at once, delayed store, timed-out load, ack-at-limit load.
      d_script.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011});
      d_script.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
      d_script.push_back('{1'b0, 32'h204, 32'h0, 4'hF});
      dly_q = '{1, 3, TO + 2, TO};
      rd_q = '{32'h0051_3093, 32'h1111_2222, 32'h3333_4444, 32'hCAFE_F00D};
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0010;
      rst = 1'b0;
      cyc = 0;
      nxt = 1;
      step();
      guard = 0;
      while (!(phase == 3 && !act && !bus.if_req && !bus.d_req)) begin
         cycle();
         if (++guard > 5000) begin
            chk("drain_timeout", 0, 1);
            break;
         end
      end
      // Reset during the second ISSUE cycle of a fetch that never gets acked.
      dly_q.delete();
      dly_q.push_back(TO + 2);
      new_if();
      guard = 0;
      while (!(act && !own_d && cyc == e + 1)) begin
         cycle();
         if (++guard > 50) begin
            chk("rst_setup_timeout", 0, 1);
            break;
         end
      end
      rst = 1'b1;
      #1;
      chk("async_mem_req", bus.mem_req, 0);
      new_d(rnd_d());
      repeat (2) begin
         @(negedge clk);
         chk("inrst_mem_req", bus.mem_req, 0);
         chk("inrst_if_done", bus.if_done, 0);
         chk("inrst_d_done", bus.d_done, 0);
      end
      rst = 1'b0;
      chk("rst_streak", 32'(dut.r_streak), 0);
      act = 1'b0;
      streak = 0;
      cyc = 0;
      nxt = 1;
      dly_q.delete();
      step();
      repeat (40) cycle();
      chk("final_idle_if", bus.if_req, 0);
      chk("final_idle_d", bus.d_req, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the cpu's instruction-fetch unit and its load/store unit.
- Sequences each access: latches the request, drives the memory handshake, waits for acknowledge or timeout, then returns read data and status to the owning requester.
- Sits between the cpu core and the memory model, inside cpu, clocked by the same clk/rst.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending.
- TIMEOUT, 255, cycles waited for mem_ack before abandoning an access. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request (level).
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_err  out  1  fetch timed out; valid with if_done.
- if_rdata  out  DATA_W  fetched word; valid with if_done.
- d_req  in  1  data request (level).
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_done  out  1  one-cycle completion pulse to load/store unit.
- d_err  out  1  data access timed out; valid with d_done.
- d_rdata  out  DATA_W  load data; valid with d_done; 0 for stores.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async):
  - All outputs go to 0 and the state goes to IDLE.
  - The streak and timeout counters clear.
  - A transaction in flight is dropped with no done pulse, and mem_req falls immediately.
- State IDLE, requests sampled:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant data, unless streak == MAX_D_STREAK, in which case grant fetch.
  - On grant, register owner, we, addr, wdata and be (fetch uses we = 0, be = all ones), then go to ISSUE.
- State ISSUE:
  - mem_req = 1 and the mem_* buses hold the latched values.
  - The timeout counter increments each cycle.
  - On mem_ack: capture mem_rdata (d_rdata is 0 if we = 1), clear err, go to RESP. mem_req falls on the next edge.
  - If the counter reaches TIMEOUT with no ack: capture rdata = 0, set err = 1, drop mem_req, go to RESP.
  - A mem_ack arriving in the same cycle as the timeout limit counts as success; ack wins.
  - A mem_ack outside ISSUE is ignored.
- State RESP:
  - The owner's done is 1 for exactly one cycle, with rdata and err valid. The non-owner's done stays 0.
  - Requests are ignored in this cycle. Next state is IDLE.
- Latency: with ack in the first ISSUE cycle, req is sampled at edge N, ISSUE runs N+1, done is high N+2. Minimum 3 cycles per access; back-to-back accesses every 3 cycles.
- Requester rule:
  - Hold req and all request fields stable from assertion until done is seen.
  - On the edge that samples done, either drop req or present the next request; that request is evaluated in the following IDLE cycle.
- Streak counter:
  - Increments on each data grant made while if_req = 1, saturating at MAX_D_STREAK.
  - Clears on any fetch grant, and on any data grant with if_req = 0.
- rdata and err outputs hold their last values between done pulses; they are meaningful only with done.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, RESP), owner encoding (OWN_IF = 0, OWN_D = 1), default parameter constants.
- One sub-module: arb_pick, the combinational grant decision (if_req, d_req, streak_full → grant_valid, owner).
- The FSM, counters and latches stay in mem_port_arbiter.

Test Plan:
- Fetch only, addr 0x0000_0010, memory acks on the first ISSUE cycle with 0x0051_3093:
  - mem_req high 1 cycle with mem_addr 0x10 and mem_we 0.
  - if_done high 2 cycles after the req edge, if_rdata 0x0051_3093, if_err 0.
- Store d_addr 0x100, wdata 0xDEAD_BEEF, be 4'b0011, ack delayed 3 cycles:
  - mem_req held 3 cycles with stable bus and be 0011.
  - One d_done pulse with d_rdata 0 and d_err 0.
  - if_done stays 0 throughout.
- if_req and d_req both held continuously, ack immediate, MAX_D_STREAK = 4:
  - Grant order D, D, D, D, IF, repeating.
  - Every done is a single-cycle pulse, 3 cycles apart.
- TIMEOUT = 5, no ack for a load: mem_req high exactly 5 cycles, then d_done with d_err 1 and d_rdata 0.
- Same setup, ack arrives in the 5th ISSUE cycle: d_err 0 and d_rdata equals mem_rdata.
- Assert rst for 2 cycles mid-ISSUE of a fetch:
  - mem_req drops asynchronously and no if_done pulse is produced.
  - After release, a pending d_req is granted from IDLE and the streak counter reads 0.
